// File: rtl/overworld_move_ctrl_pkg.sv
// Shared types and keycode constants for the overworld movement controller.
package move_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    WALK = 2'd2
  } move_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] k);
    key_dec_t r;
    r.valid = 1'b1;
    r.dir   = DOWN;
    case (k)
      KEY_W:   r.dir = UP;
      KEY_D:   r.dir = RIGHT;
      KEY_S:   r.dir = DOWN;
      KEY_A:   r.dir = LEFT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/overworld_move_ctrl_if.sv
// Keyboard/VS inputs and sprite-control outputs of the movement controller.
interface overworld_move_ctrl_if;
  logic       VS;
  logic [7:0] keycode;
  logic       Character_Moving;
  logic [1:0] Direction;
  logic       Step_Pulse;
  logic [6:0] Tile_X;
  logic [6:0] Tile_Y;

  modport master (
    output VS, keycode,
    input  Character_Moving, Direction, Step_Pulse, Tile_X, Tile_Y
  );

  modport slave (
    input  VS, keycode,
    output Character_Moving, Direction, Step_Pulse, Tile_X, Tile_Y
  );
endinterface

// File: rtl/overworld_move_ctrl_vs_tick_sync.sv
// Brings the asynchronous VGA vertical sync into the Clk domain and emits a
// one-cycle pulse on each synchronized rising edge.
module vs_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vs_i,
  output logic frame_tick_o
);

  // [0],[1] are the metastability pair, [2] holds the previous synced value
  logic [2:0] sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], vs_i};
  end

  assign frame_tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/overworld_move_ctrl.sv
// Tile-stepped player movement: turn-in-place on short taps, whole-tile steps
// once walking starts, tile coordinates tracked for collision/encounters.
module overworld_move_ctrl
  import move_pkg::*;
#(
  parameter int STEP_FRAMES = 16,
  parameter int TURN_FRAMES = 4,
  parameter int TILE_X_MAX  = 79,
  parameter int TILE_Y_MAX  = 59,
  parameter int INIT_TILE_X = 25,
  parameter int INIT_TILE_Y = 25
) (
  input logic Clk,
  input logic Reset_n,
  overworld_move_ctrl_if.slave bus
);

  localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int TW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_FRAMES - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_FRAMES - 1);
  localparam logic [6:0] X_MAX  = 7'(TILE_X_MAX);
  localparam logic [6:0] Y_MAX  = 7'(TILE_Y_MAX);
  localparam logic [6:0] X_INIT = 7'(INIT_TILE_X);
  localparam logic [6:0] Y_INIT = 7'(INIT_TILE_Y);

  function automatic logic in_bounds(input dir_t d, input logic [6:0] x,
                                     input logic [6:0] y);
    logic r;
    case (d)
      UP:      r = (y != 7'd0);
      DOWN:    r = (y < Y_MAX);
      LEFT:    r = (x != 7'd0);
      RIGHT:   r = (x < X_MAX);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic frame_tick;

  vs_tick_sync u_vs_sync (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .vs_i         (bus.VS),
    .frame_tick_o (frame_tick)
  );

  move_state_t   state_q, state_d;
  dir_t          dir_q, dir_d;
  logic          moving_q, moving_d;
  logic          pulse_q, pulse_d;
  logic [6:0]    tile_x_q, tile_x_d;
  logic [6:0]    tile_y_q, tile_y_d;
  logic [SW-1:0] step_q, step_d;
  logic [TW-1:0] turn_q, turn_d;

  key_dec_t   key;
  logic [6:0] x_step, y_step;

  assign key = decode_key(bus.keycode);

  // Tile reached when the current step finishes; bounds were checked on entry
  always_comb begin
    x_step = tile_x_q;
    y_step = tile_y_q;
    case (dir_q)
      UP:      y_step = tile_y_q - 7'd1;
      DOWN:    y_step = tile_y_q + 7'd1;
      LEFT:    x_step = tile_x_q - 7'd1;
      RIGHT:   x_step = tile_x_q + 7'd1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    pulse_d  = 1'b0;
    tile_x_d = tile_x_q;
    tile_y_d = tile_y_q;
    step_d   = step_q;
    turn_d   = turn_q;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (key.valid) begin
            if (key.dir != dir_q) begin
              dir_d   = key.dir;
              turn_d  = '0;
              state_d = TURN;
            end else if (in_bounds(key.dir, tile_x_q, tile_y_q)) begin
              step_d   = '0;
              moving_d = 1'b1;
              state_d  = WALK;
            end
          end
        end
        TURN: begin
          if (!key.valid) begin
            state_d = IDLE;
          end else if (key.dir != dir_q) begin
            dir_d  = key.dir;
            turn_d = '0;
          end else if (turn_q == TURN_LAST) begin
            if (in_bounds(key.dir, tile_x_q, tile_y_q)) begin
              step_d   = '0;
              moving_d = 1'b1;
              state_d  = WALK;
            end else begin
              state_d = IDLE;
            end
          end else begin
            turn_d = turn_q + TW'(1);
          end
        end
        WALK: begin
          if (step_q < STEP_LAST) begin
            step_d = step_q + SW'(1);
          end else begin
            tile_x_d = x_step;
            tile_y_d = y_step;
            pulse_d  = 1'b1;
            step_d   = '0;
            // Chained steps turn without the in-place pause
            if (key.valid && in_bounds(key.dir, x_step, y_step)) begin
              dir_d = key.dir;
            end else begin
              moving_d = 1'b0;
              state_d  = IDLE;
              if (key.valid) dir_d = key.dir;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      dir_q    <= DOWN;
      moving_q <= 1'b0;
      pulse_q  <= 1'b0;
      tile_x_q <= X_INIT;
      tile_y_q <= Y_INIT;
      step_q   <= '0;
      turn_q   <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      pulse_q  <= pulse_d;
      tile_x_q <= tile_x_d;
      tile_y_q <= tile_y_d;
      step_q   <= step_d;
      turn_q   <= turn_d;
    end
  end

  assign bus.Character_Moving = moving_q;
  assign bus.Direction        = dir_q;
  assign bus.Step_Pulse       = pulse_q;
  assign bus.Tile_X           = tile_x_q;
  assign bus.Tile_Y           = tile_y_q;

endmodule

// File: tb/tb_overworld_move_ctrl.sv
// Bench for overworld_move_ctrl: two instances (centre start, and a corner
// start with a narrow map) compared per frame against a tile-level model.
module tb_overworld_move_ctrl;

  localparam int SF = 16;
  localparam int TF = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  overworld_move_ctrl_if ifa ();
  overworld_move_ctrl_if ifb ();

  overworld_move_ctrl u_a (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifa.slave)
  );

  overworld_move_ctrl #(
    .TILE_X_MAX  (3),
    .INIT_TILE_X (0),
    .INIT_TILE_Y (59)
  ) u_b (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifb.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  int xmax[2]  = '{79, 3};
  int ymax[2]  = '{59, 59};
  int xinit[2] = '{25, 0};
  int yinit[2] = '{25, 59};
  int dx[4]    = '{0, 1, 0, -1};
  int dy[4]    = '{-1, 0, 1, 0};

  // model: mode 0 standing, 1 turning, 2 mid-step
  int m_mode[2], m_dir[2], m_x[2], m_y[2], m_step[2], m_turn[2], m_pulse[2];
  bit m_mov[2];

  int pcnt[2];
  logic [20:0] obs[2];
  logic [20:0] expv[2];

  always @(negedge Clk) begin
    pcnt[0] = pcnt[0] + int'(ifa.Step_Pulse);
    pcnt[1] = pcnt[1] + int'(ifb.Step_Pulse);
  end

  function automatic logic [20:0] pack(input logic mov, input logic [1:0] d,
                                       input logic [6:0] x, input logic [6:0] y,
                                       input int p);
    return {mov, d, x, y, 4'((p > 15) ? 15 : p)};
  endfunction

  function automatic bit inb(input int i, input int d, input int x, input int y);
    int nx, ny;
    nx = x + dx[d];
    ny = y + dy[d];
    return (nx >= 0) && (nx <= xmax[i]) && (ny >= 0) && (ny <= ymax[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_dir[i] = 2; m_x[i] = xinit[i]; m_y[i] = yinit[i];
      m_step[i] = 0; m_turn[i] = 0; m_mov[i] = 1'b0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_tick(input logic [7:0] key);
    bit kv;
    int kd;
    kv = 1'b1;
    kd = 0;
    case (key)
      8'h1A:   kd = 0;
      8'h07:   kd = 1;
      8'h16:   kd = 2;
      8'h04:   kd = 3;
      default: kv = 1'b0;
    endcase
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (m_mode[i] == 0) begin
        if (kv && kd != m_dir[i]) begin
          m_dir[i] = kd; m_turn[i] = 0; m_mode[i] = 1;
        end else if (kv && inb(i, kd, m_x[i], m_y[i])) begin
          m_step[i] = 0; m_mov[i] = 1'b1; m_mode[i] = 2;
        end
      end else if (m_mode[i] == 1) begin
        if (!kv) m_mode[i] = 0;
        else if (kd != m_dir[i]) begin
          m_dir[i] = kd; m_turn[i] = 0;
        end else if (m_turn[i] == TF - 1) begin
          if (inb(i, kd, m_x[i], m_y[i])) begin
            m_step[i] = 0; m_mov[i] = 1'b1; m_mode[i] = 2;
          end else m_mode[i] = 0;
        end else m_turn[i]++;
      end else begin
        if (m_step[i] < SF - 1) m_step[i]++;
        else begin
          m_x[i] += dx[m_dir[i]];
          m_y[i] += dy[m_dir[i]];
          m_pulse[i] = 1;
          m_step[i] = 0;
          if (kv && inb(i, kd, m_x[i], m_y[i])) m_dir[i] = kd;
          else begin
            m_mov[i] = 1'b0; m_mode[i] = 0;
            if (kv) m_dir[i] = kd;
          end
        end
      end
    end
  endtask

  task automatic fill_expected();
    obs[0] = pack(ifa.Character_Moving, ifa.Direction, ifa.Tile_X, ifa.Tile_Y, pcnt[0]);
    obs[1] = pack(ifb.Character_Moving, ifb.Direction, ifb.Tile_X, ifb.Tile_Y, pcnt[1]);
    for (int i = 0; i < 2; i++)
      expv[i] = pack(m_mov[i], 2'(m_dir[i]), 7'(m_x[i]), 7'(m_y[i]), m_pulse[i]);
  endtask

  // One VS frame with key held across the edge; junk keycode afterwards
  task automatic tick(input logic [7:0] key);
    @(negedge Clk); #1;
    pcnt[0] = 0; pcnt[1] = 0;
    ifa.keycode = key; ifb.keycode = key;
    ifa.VS = 1'b1; ifb.VS = 1'b1;
    repeat (4) @(negedge Clk);
    #1 ifa.VS = 1'b0; ifb.VS = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    model_tick(key);
    fill_expected();
    ifa.keycode = 8'($urandom); ifb.keycode = 8'($urandom);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    #1;
    model_reset();
    pcnt[0] = 0; pcnt[1] = 0;
    fill_expected();
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (obs[i] !== expv[i]) $display("FAIL reset_hold dut%0d: got %h want %h", i, obs[i], expv[i]);
      else n_pass++;
    end
    Reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick(8'h00);
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (obs[i] !== expv[i]) $display("FAIL reset_idle dut%0d t%0d: got %h want %h", i, t, obs[i], expv[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_latency();
    logic [1:0] want[3] = '{2'd2, 2'd2, 2'd1};
    @(negedge Clk); #1;
    ifa.keycode = 8'h07; ifb.keycode = 8'h07;
    ifa.VS = 1'b1; ifb.VS = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge Clk); #1;
      n_total++;
      if (ifa.Direction !== want[e] || ifb.Direction !== want[e])
        $display("FAIL latency edge%0d: got %0d/%0d want %0d", e + 1, ifa.Direction, ifb.Direction, want[e]);
      else n_pass++;
    end
    repeat (2) @(negedge Clk);
    #1 ifa.VS = 1'b0; ifb.VS = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    model_tick(8'h07);
  endtask

  task automatic test_turn_walk();
    for (int t = 0; t < 40; t++) begin
      tick(8'h07);
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (obs[i] !== expv[i]) $display("FAIL turn_walk dut%0d t%0d: got %h want %h", i, t, obs[i], expv[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic run_keys(input string name, input logic [7:0] keys[$]);
    foreach (keys[t]) begin
      tick(keys[t]);
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (obs[i] !== expv[i]) $display("FAIL %s dut%0d t%0d: got %h want %h", name, i, t, obs[i], expv[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_tap_turn();
    logic [7:0] k[$];
    repeat (18) k.push_back(8'h00);
    k.push_back(8'h16); k.push_back(8'h00);
    k.push_back(8'h1A); k.push_back(8'h1A); k.push_back(8'h00); k.push_back(8'h00);
    run_keys("tap_turn", k);
  endtask

  task automatic test_release_mid_step();
    logic [7:0] k[$];
    k.push_back(8'h16); k.push_back(8'h00);
    k.push_back(8'h16);
    repeat (18) k.push_back(8'h00);
    run_keys("mid_step", k);
  endtask

  task automatic test_boundary();
    logic [7:0] k[$];
    repeat (70) k.push_back(8'h04);
    repeat (26) k.push_back(8'h07);
    repeat (18) k.push_back(8'h00);
    repeat (6) k.push_back(8'h16);
    run_keys("boundary", k);
  endtask

  task automatic test_async_reset();
    logic [7:0] k[$];
    k.push_back(8'h00); k.push_back(8'h16); k.push_back(8'h00); k.push_back(8'h16);
    repeat (8) k.push_back(8'h00);
    run_keys("pre_reset", k);
    @(negedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    pcnt[0] = 0; pcnt[1] = 0;
    fill_expected();
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (obs[i] !== expv[i]) $display("FAIL async_reset dut%0d: got %h want %h", i, obs[i], expv[i]);
      else n_pass++;
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    k.delete();
    repeat (20) k.push_back(8'h00);
    run_keys("post_reset", k);
  endtask

  task automatic test_random();
    logic [7:0] pool[6] = '{8'h00, 8'h1A, 8'h07, 8'h16, 8'h04, 8'h05};
    logic [7:0] k[$];
    while (k.size() < 300) begin
      logic [7:0] key;
      int hold;
      key = pool[$urandom_range(0, 5)];
      if (key == 8'h05) key = 8'($urandom);
      hold = $urandom_range(1, 20);
      repeat (hold) k.push_back(key);
    end
    run_keys("random", k);
  endtask

  initial begin
    ifa.VS = 1'b0; ifb.VS = 1'b0;
    ifa.keycode = 8'h00; ifb.keycode = 8'h00;
    test_reset();
    test_latency();
    test_turn_walk();
    test_tap_turn();
    test_release_mid_step();
    test_boundary();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
